// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grant is held from grant through beginTransaction..endTransaction, then rotates.
// Optional BUS_ARB_WATCHDOG_EN adds a BUSY-state watchdog that revokes a grant after WDT_CYCLES.
module bus_arbiter #(
   parameter int NUM_MASTERS   = 4,
   parameter int GRANT_TIMEOUT = 16,
   parameter int WDT_CYCLES    = 1024,
   localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_MASTERS-1:0] arb_requests_i,
   output logic [NUM_MASTERS-1:0] arb_grants_o,
   output logic [IDW-1:0]         arb_owner_o,
   output logic                   arb_active_o,
   input  logic                   bus_beginTransaction_i,
   input  logic                   bus_endTransaction_i,
   input  logic                   bus_error_i,
   output logic                   arb_timeout_o,
   output logic                   wdt_error_o
);

   localparam int TW = $clog2(GRANT_TIMEOUT);

   if (NUM_MASTERS < 1 || NUM_MASTERS > 32 || GRANT_TIMEOUT < 2 || WDT_CYCLES < 2) begin : gBadParams
      $error("bus_arbiter: illegal parameter value");
   end

   typedef enum logic [1:0] {IDLE, GRANT, BUSY} stateT;

   stateT                  state, stateNext;
   logic [NUM_MASTERS-1:0] grants, grantsNext;
   logic [IDW-1:0]         owner, ownerNext;
   logic [IDW-1:0]         ptr, ptrNext;
   logic [TW-1:0]          tcnt, tcntNext;
   logic                   timeoutPulse, timeoutNext;
   logic                   reqFound;
   logic [IDW-1:0]         selIdx;
   logic                   dropGrant;
`ifdef BUS_ARB_WATCHDOG_EN
   localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
   logic [WW-1:0]          wcnt, wcntNext;
   logic                   wdtPulse, wdtNext;
`endif

   // Index base+offs wrapped into 0..NUM_MASTERS-1 (offs < NUM_MASTERS).
   function automatic logic [IDW-1:0] wrapIdx(input logic [IDW-1:0] base, input int offs);
      int s;
      s = int'(base) + offs;
      if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
      return IDW'(s);
   endfunction

   always_comb begin
      reqFound = 1'b0;
      selIdx   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!reqFound && arb_requests_i[wrapIdx(ptr, i)]) begin
            reqFound = 1'b1;
            selIdx   = wrapIdx(ptr, i);
         end
      end
   end

   always_comb begin
      stateNext   = state;
      grantsNext  = grants;
      ownerNext   = owner;
      ptrNext     = ptr;
      tcntNext    = tcnt;
      timeoutNext = 1'b0;
      dropGrant   = 1'b0;
`ifdef BUS_ARB_WATCHDOG_EN
      wcntNext    = wcnt;
      wdtNext     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (reqFound) begin
               stateNext  = GRANT;
               grantsNext = NUM_MASTERS'(1) << selIdx;
               ownerNext  = selIdx;
               tcntNext   = '0;
            end
         end
         GRANT: begin
            tcntNext = tcnt + 1'b1;
            // begin outranks both a dropped request and the timeout
            if (bus_beginTransaction_i) begin
               stateNext = BUSY;
`ifdef BUS_ARB_WATCHDOG_EN
               wcntNext  = '0;
`endif
            end else if (!arb_requests_i[owner]) begin
               dropGrant = 1'b1;
            end else if (tcnt == TW'(GRANT_TIMEOUT - 1)) begin
               dropGrant   = 1'b1;
               timeoutNext = 1'b1;
            end
         end
         BUSY: begin
            if (bus_endTransaction_i || bus_error_i) begin
               dropGrant = 1'b1;
`ifdef BUS_ARB_WATCHDOG_EN
            end else if (wcnt == WW'(WDT_CYCLES - 1)) begin
               dropGrant = 1'b1;
               wdtNext   = 1'b1;
            end else begin
               wcntNext = wcnt + 1'b1;
`endif
            end
         end
         default: stateNext = IDLE;
      endcase
      if (dropGrant) begin
         stateNext  = IDLE;
         grantsNext = '0;
         ptrNext    = wrapIdx(owner, 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         grants       <= '0;
         owner        <= '0;
         ptr          <= '0;
         tcnt         <= '0;
         timeoutPulse <= 1'b0;
`ifdef BUS_ARB_WATCHDOG_EN
         wcnt         <= '0;
         wdtPulse     <= 1'b0;
`endif
      end else begin
         state        <= stateNext;
         grants       <= grantsNext;
         owner        <= ownerNext;
         ptr          <= ptrNext;
         tcnt         <= tcntNext;
         timeoutPulse <= timeoutNext;
`ifdef BUS_ARB_WATCHDOG_EN
         wcnt         <= wcntNext;
         wdtPulse     <= wdtNext;
`endif
      end
   end

   assign arb_grants_o  = grants;
   assign arb_owner_o   = owner;
   assign arb_active_o  = (state != IDLE);
   assign arb_timeout_o = timeoutPulse;
`ifdef BUS_ARB_WATCHDOG_EN
   assign wdt_error_o   = wdtPulse;
`else
   assign wdt_error_o   = 1'b0;
`endif

   grantOneHot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(arb_grants_o));

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed stimulus queues expected grant/pulse events, a negedge monitor checks them.
module tb_bus_arbiter;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] requests;
   logic         beginT, endT, err;
   logic [N-1:0] grants;
   logic [1:0]   owner;
   logic         active, timeoutP, wdtP;

   bus_arbiter #(.NUM_MASTERS(N), .GRANT_TIMEOUT(16), .WDT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .arb_requests_i(requests), .arb_grants_o(grants),
      .arb_owner_o(owner), .arb_active_o(active),
      .bus_beginTransaction_i(beginT), .bus_endTransaction_i(endT), .bus_error_i(err),
      .arb_timeout_o(timeoutP), .wdt_error_o(wdtP));

   always #5 clk = ~clk;

   typedef enum int {EV_GRANT, EV_TIMEOUT, EV_WDT} evKindT;
   typedef struct { evKindT kind; logic [N-1:0] grant; logic [1:0] owner; } evT;

   evT          expQ[$];
   int          compared   = 0;
   int          mismatched = 0;
   logic [N-1:0] prevGrants = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pushEv(input evKindT k, input logic [N-1:0] g, input logic [1:0] o);
      evT e;
      e.kind = k; e.grant = g; e.owner = o;
      expQ.push_back(e);
   endtask

   task automatic observe(input evKindT k, input logic [N-1:0] g, input logic [1:0] o);
      evT e;
      if (expQ.size() == 0) begin
         compared++; mismatched++;
         $display("FAIL unexpected event: got kind=%0d grant=%b owner=%0d, expected none", int'(k), g, o);
      end else begin
         e = expQ.pop_front();
         check("event kind", int'(k), int'(e.kind));
         if (e.kind == EV_GRANT) begin
            check("grant vector", g, e.grant);
            check("grant owner", o, e.owner);
         end
      end
   endtask

   // Monitor: sampled on the falling edge, away from register updates.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prevGrants = '0;
      end else begin
         check("grant one-hot", $onehot0(grants), 1);
         if (timeoutP) observe(EV_TIMEOUT, grants, owner);
         if (wdtP) observe(EV_WDT, grants, owner);
         if (grants != 0 && grants != prevGrants) begin
            check("turnaround gap", prevGrants, 0);
            observe(EV_GRANT, grants, owner);
         end
         prevGrants = grants;
      end
   end

   initial begin
      #200000;
      $display("FAIL global time limit: got no finish, expected finish");
      $fatal(1, "time limit");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic waitGrant(input string name);
      int n = 0;
      while (grants == 0 && n < 50) begin
         step(1);
         n++;
      end
      check({name, " grant wait"}, (grants != 0), 1);
   endtask

   task automatic doTransaction(input logic [N-1:0] busyReq);
      waitGrant("tx");
      beginT = 1'b1;
      step(1);
      beginT   = 1'b0;
      requests = busyReq;
      check("active in BUSY", active, 1);
      step(2);
      endT = 1'b1;
      step(1);
      endT = 1'b0;
      check("released after end", grants, 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; requests = 4'hF; beginT = 1'b0; endT = 1'b0; err = 1'b0;

      // reset state and first-grant latency
      step(3);
      check("reset grants", grants, 0);
      check("reset owner", owner, 0);
      check("reset active", active, 0);
      check("reset timeout", timeoutP, 0);
      check("reset wdt", wdtP, 0);
      pushEv(EV_GRANT, 4'b0001, 2'd0);
      rst_n = 1'b1;
      step(1);
      check("grant latency", grants, 4'b0001);

      // rotation with all requesting, then skip idle masters
      pushEv(EV_GRANT, 4'b0010, 2'd1);
      pushEv(EV_GRANT, 4'b0100, 2'd2);
      pushEv(EV_GRANT, 4'b1000, 2'd3);
      pushEv(EV_GRANT, 4'b0001, 2'd0);
      pushEv(EV_GRANT, 4'b0010, 2'd1);
      pushEv(EV_GRANT, 4'b1000, 2'd3);
      pushEv(EV_GRANT, 4'b0010, 2'd1);
      pushEv(EV_GRANT, 4'b0100, 2'd2);
      doTransaction(4'hF);
      doTransaction(4'hF);
      doTransaction(4'hF);
      doTransaction(4'hF);
      doTransaction(4'b1010);
      doTransaction(4'b1010);
      doTransaction(4'b1010);
      doTransaction(4'b1100);

      // timeout: master 2 never begins
      pushEv(EV_TIMEOUT, '0, 2'd0);
      pushEv(EV_GRANT, 4'b1000, 2'd3);
      waitGrant("timeout");
      n = 0;
      while (grants != 0 && n < 40) begin
         step(1);
         n++;
      end
      check("timeout hold cycles", n, 16);
      check("timeout pulse", timeoutP, 1);
      step(1);
      check("after timeout grant", grants, 4'b1000);
      check("after timeout pulse low", timeoutP, 0);

      // request drop together with begin, end+begin in BUSY, error in BUSY
      requests = 4'b0100;
      beginT   = 1'b1;
      step(1);
      beginT = 1'b0;
      check("begin beats drop grant", grants, 4'b1000);
      check("begin beats drop active", active, 1);
      step(3);
      check("BUSY ignores requests", grants, 4'b1000);
      endT = 1'b1; beginT = 1'b1;
      step(1);
      endT = 1'b0; beginT = 1'b0;
      check("end wins over begin", grants, 0);
      check("end wins active", active, 0);
      pushEv(EV_GRANT, 4'b0100, 2'd2);
      step(1);
      check("regrant after end", grants, 4'b0100);
      beginT = 1'b1;
      step(1);
      beginT = 1'b0; requests = '0;
      step(2);
      err = 1'b1;
      step(1);
      err = 1'b0;
      check("error releases grant", grants, 0);
      step(5);
      check("idle with no requests", grants, 0);
      check("idle active", active, 0);

      // watchdog (or indefinite hold without it)
      requests = 4'b0001;
      pushEv(EV_GRANT, 4'b0001, 2'd0);
`ifdef BUS_ARB_WATCHDOG_EN
      pushEv(EV_WDT, '0, 2'd0);
`endif
      waitGrant("wdt");
      beginT = 1'b1;
      step(1);
      beginT = 1'b0; requests = '0;
      n = 0;
`ifdef BUS_ARB_WATCHDOG_EN
      while (grants != 0 && n < 40) begin
         step(1);
         n++;
      end
      check("watchdog cycles", n, 8);
      check("watchdog pulse", wdtP, 1);
`else
      while (grants != 0 && n < 120) begin
         step(1);
         n++;
         check("no-watchdog pulse", wdtP, 0);
      end
      check("no-watchdog hold cycles", n, 120);
      check("no-watchdog grant", grants, 4'b0001);
      endT = 1'b1;
      step(1);
      endT = 1'b0;
      check("no-watchdog release", grants, 0);
`endif

      // asynchronous reset mid-transaction
      requests = 4'b0010;
      pushEv(EV_GRANT, 4'b0010, 2'd1);
      waitGrant("async reset");
      beginT = 1'b1;
      step(1);
      beginT = 1'b0;
      check("busy before reset", grants, 4'b0010);
      #2 rst_n = 1'b0;
      #1;
      check("async reset grants", grants, 0);
      check("async reset active", active, 0);
      check("async reset owner", owner, 0);
      requests = '0;
      step(2);
      check("scoreboard drained", expQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
